// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding mux
// select codes, hazard FSM states and the per-stage tracking record.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        SEL_RF    = 2'b00,
        SEL_EXMEM = 2'b01,
        SEL_MEMWB = 2'b10,
        SEL_ALT   = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, is_load: 1'b0};

    // True when stage s will produce a value for register r (x0 never forwards).
    function automatic logic writes_reg(input stage_t s, input logic [4:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_pick.sv
// Priority compare of one source register against the EX and MEM entries,
// producing the operand mux select.
import hazard_ctrl_pkg::*;

module fwd_pick (
    input  logic       use_alt,
    input  logic       use_rs,
    input  logic [4:0] rs,
    input  stage_t     ex,
    input  stage_t     mem,
    output fwd_sel_e   sel
);

    always_comb begin
        sel = SEL_RF;
        if (use_alt)
            sel = SEL_ALT;
        else if (use_rs && writes_reg(ex, rs))
            sel = SEL_EXMEM;
        else if (use_rs && writes_reg(mem, rs))
            sel = SEL_MEMWB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: registered forwarding selects, load-use stall and
// branch flush for a 5-stage in-order pipeline.
import hazard_ctrl_pkg::*;

module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_a_pc,
    input  logic       id_b_imm,
    input  logic [4:0] id_rd,
    input  logic       id_reg_write,
    input  logic       id_is_load,
    input  logic       branch_taken,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall,
    output logic       flush,
    output logic       ex_bubble
);

    hz_state_e state_q;
    stage_t    ex_q;
    stage_t    mem_q;
    stage_t    id_entry;
    fwd_sel_e  fwd_a_q;
    fwd_sel_e  fwd_b_q;
    fwd_sel_e  pick_a;
    fwd_sel_e  pick_b;
    logic      bubble_q;
    logic      load_use;
    logic      admit;

    fwd_pick u_pick_a (
        .use_alt (id_a_pc),
        .use_rs  (id_use_rs1),
        .rs      (id_rs1),
        .ex      (ex_q),
        .mem     (mem_q),
        .sel     (pick_a)
    );

    fwd_pick u_pick_b (
        .use_alt (id_b_imm),
        .use_rs  (id_use_rs2),
        .rs      (id_rs2),
        .ex      (ex_q),
        .mem     (mem_q),
        .sel     (pick_b)
    );

    always_comb begin
        load_use = id_valid && ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_q.rd)));
    end

    // A redirect overrides a coincident load-use hazard.
    assign stall = (state_q == RUN) && load_use && !branch_taken;
    assign flush = branch_taken || (state_q == FLUSH);
    assign admit = id_valid && !stall && !flush;

    assign id_entry = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            ex_q     <= STAGE_EMPTY;
            mem_q    <= STAGE_EMPTY;
            fwd_a_q  <= SEL_RF;
            fwd_b_q  <= SEL_RF;
            bubble_q <= 1'b1;
        end else begin
            mem_q    <= ex_q;
            ex_q     <= admit ? id_entry : STAGE_EMPTY;
            fwd_a_q  <= admit ? pick_a : SEL_RF;
            fwd_b_q  <= admit ? pick_b : SEL_RF;
            bubble_q <= !admit;
            if (branch_taken) begin
                state_q <= FLUSH;
            end else begin
                case (state_q)
                    RUN:     state_q <= stall ? STALL : RUN;
                    STALL:   state_q <= RUN;
                    FLUSH:   state_q <= RUN;
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign ex_bubble = bubble_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus a
// randomized run against a history-based reference model.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_a_pc;
    logic       id_b_imm;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       branch_taken;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
    logic       flush;
    logic       ex_bubble;

    int errors = 0;
    int checks = 0;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_a_pc      (id_a_pc),
        .id_b_imm     (id_b_imm),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .branch_taken (branch_taken),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .flush        (flush),
        .ex_bubble    (ex_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit u1, input bit u2, input bit apc, input bit bimm,
                         input bit [4:0] rd, input bit rw, input bit ld, input bit br);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_a_pc      = apc;
        id_b_imm     = bimm;
        id_rd        = rd;
        id_reg_write = rw;
        id_is_load   = ld;
        branch_taken = br;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        nop();
        tick();
        tick();
        checks += 5;
        if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %0d expected 0", fwd_a_sel); end
        if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %0d expected 0", fwd_b_sel); end
        if (ex_bubble !== 1'b1)  begin errors++; $display("FAIL reset_bubble: got %0d expected 1", ex_bubble); end
        if (stall !== 1'b0)      begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall); end
        if (flush !== 1'b0)      begin errors++; $display("FAIL reset_flush: got %0d expected 0", flush); end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 1, 2, 1, 1, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 5, 1, 1, 1, 0, 0, 6, 1, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %0d expected 0", stall); end
        tick();
        nop();
        checks += 3;
        if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL b2b_fwd_a: got %0d expected 1", fwd_a_sel); end
        if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL b2b_fwd_b: got %0d expected 0", fwd_b_sel); end
        if (ex_bubble !== 1'b0)  begin errors++; $display("FAIL b2b_bubble: got %0d expected 0", ex_bubble); end
    endtask

    task automatic test_distance2();
        do_reset();
        drive(1, 1, 2, 1, 1, 0, 0, 7, 1, 0, 0);
        tick();
        drive(1, 1, 2, 1, 1, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 1, 7, 1, 1, 0, 0, 4, 1, 0, 0);
        tick();
        nop();
        checks += 2;
        if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL dist2_fwd_b: got %0d expected 2", fwd_b_sel); end
        if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL dist2_fwd_a: got %0d expected 0", fwd_a_sel); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 2, 0, 1, 0, 0, 1, 8, 1, 1, 0);
        tick();
        drive(1, 8, 8, 1, 1, 0, 0, 9, 1, 0, 0);
        #1;
        checks += 2;
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_on: got %0d expected 1", stall); end
        if (flush !== 1'b0) begin errors++; $display("FAIL lu_flush: got %0d expected 0", flush); end
        tick();
        checks += 2;
        if (stall !== 1'b0)     begin errors++; $display("FAIL lu_stall_off: got %0d expected 0", stall); end
        if (ex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %0d expected 1", ex_bubble); end
        tick();
        nop();
        checks += 3;
        if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL lu_fwd_a: got %0d expected 2", fwd_a_sel); end
        if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL lu_fwd_b: got %0d expected 2", fwd_b_sel); end
        if (ex_bubble !== 1'b0)  begin errors++; $display("FAIL lu_admit: got %0d expected 0", ex_bubble); end
    endtask

    task automatic test_x0_imm();
        do_reset();
        drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 1, 1, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 1, 2, 1, 1, 0, 0, 4, 1, 0, 0);
        checks += 2;
        if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL x0_fwd_a: got %0d expected 0", fwd_a_sel); end
        if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL x0_fwd_b: got %0d expected 0", fwd_b_sel); end
        tick();
        drive(1, 4, 4, 1, 1, 1, 1, 5, 1, 0, 0);
        tick();
        nop();
        checks += 2;
        if (fwd_b_sel !== 2'b11) begin errors++; $display("FAIL imm_fwd_b: got %0d expected 3", fwd_b_sel); end
        if (fwd_a_sel !== 2'b11) begin errors++; $display("FAIL pc_fwd_a: got %0d expected 3", fwd_a_sel); end
    endtask

    task automatic test_branch_collision();
        do_reset();
        drive(1, 2, 0, 1, 0, 0, 1, 8, 1, 1, 0);
        tick();
        drive(1, 8, 8, 1, 1, 0, 0, 9, 1, 0, 1);
        #1;
        checks += 2;
        if (flush !== 1'b1) begin errors++; $display("FAIL bc_flush1: got %0d expected 1", flush); end
        if (stall !== 1'b0) begin errors++; $display("FAIL bc_stall1: got %0d expected 0", stall); end
        tick();
        branch_taken = 1'b0;
        #1;
        checks += 3;
        if (flush !== 1'b1)     begin errors++; $display("FAIL bc_flush2: got %0d expected 1", flush); end
        if (stall !== 1'b0)     begin errors++; $display("FAIL bc_stall2: got %0d expected 0", stall); end
        if (ex_bubble !== 1'b1) begin errors++; $display("FAIL bc_bubble2: got %0d expected 1", ex_bubble); end
        tick();
        checks += 2;
        if (flush !== 1'b0)     begin errors++; $display("FAIL bc_flush3: got %0d expected 0", flush); end
        if (ex_bubble !== 1'b1) begin errors++; $display("FAIL bc_bubble3: got %0d expected 1", ex_bubble); end
        tick();
        nop();
        checks += 2;
        if (ex_bubble !== 1'b0)  begin errors++; $display("FAIL bc_admit: got %0d expected 0", ex_bubble); end
        if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL bc_fwd_a: got %0d expected 0", fwd_a_sel); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        drive(1, 1, 2, 1, 1, 0, 0, 3, 1, 0, 1);
        tick();
        branch_taken = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b1) begin errors++; $display("FAIL rf_flush_state: got %0d expected 1", flush); end
        tick();
        reset = 1'b0;
        nop();
        #1;
        checks += 5;
        if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL rf_fwd_a: got %0d expected 0", fwd_a_sel); end
        if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL rf_fwd_b: got %0d expected 0", fwd_b_sel); end
        if (ex_bubble !== 1'b1)  begin errors++; $display("FAIL rf_bubble: got %0d expected 1", ex_bubble); end
        if (stall !== 1'b0)      begin errors++; $display("FAIL rf_stall: got %0d expected 0", stall); end
        if (flush !== 1'b0)      begin errors++; $display("FAIL rf_flush: got %0d expected 0", flush); end
    endtask

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       ld;
    } ent_t;

    // Model: the last two cycles' admissions, newest first; mode 0 normal,
    // 1 the cycle right after a stall, 2 the cycle right after a redirect.
    task automatic test_random();
        ent_t     pipe[$];
        ent_t     bub;
        ent_t     ex;
        ent_t     mem;
        int       mode;
        int       ea, eb;
        bit       ebub, es, ef, adm;
        bit       v, u1, u2, apc, bimm, rw, ld, br, rst;
        bit [4:0] rs1, rs2, rd;
        bub = '{v: 0, rd: 0, rw: 0, ld: 0};
        do_reset();
        pipe = {bub, bub};
        mode = 0;
        ea = 0;
        eb = 0;
        ebub = 1;
        for (int c = 0; c < 800; c++) begin
            checks += 3;
            if (fwd_a_sel !== ea[1:0]) begin errors++; $display("FAIL rnd_fwd_a c=%0d: got %0d expected %0d", c, fwd_a_sel, ea); end
            if (fwd_b_sel !== eb[1:0]) begin errors++; $display("FAIL rnd_fwd_b c=%0d: got %0d expected %0d", c, fwd_b_sel, eb); end
            if (ex_bubble !== ebub)    begin errors++; $display("FAIL rnd_bubble c=%0d: got %0d expected %0d", c, ex_bubble, ebub); end

            v    = ($urandom_range(0, 9) < 8);
            rs1  = 5'($urandom_range(0, 3));
            rs2  = 5'($urandom_range(0, 3));
            u1   = ($urandom_range(0, 3) != 0);
            u2   = ($urandom_range(0, 3) != 0);
            apc  = ($urandom_range(0, 7) == 0);
            bimm = ($urandom_range(0, 4) == 0);
            rd   = 5'($urandom_range(0, 3));
            rw   = ($urandom_range(0, 4) != 0);
            ld   = ($urandom_range(0, 2) == 0);
            br   = ($urandom_range(0, 15) == 0);
            rst  = ($urandom_range(0, 59) == 0);
            drive(v, rs1, rs2, u1, u2, apc, bimm, rd, rw, ld, br);
            reset = rst;
            #1;

            ex  = pipe[0];
            mem = pipe[1];
            es = (mode == 0) && !br && v && ex.v && ex.ld && ex.rd != 0 &&
                 ((u1 && rs1 == ex.rd) || (u2 && rs2 == ex.rd));
            ef = br || (mode == 2);
            checks += 2;
            if (stall !== es) begin errors++; $display("FAIL rnd_stall c=%0d: got %0d expected %0d", c, stall, es); end
            if (flush !== ef) begin errors++; $display("FAIL rnd_flush c=%0d: got %0d expected %0d", c, flush, ef); end

            adm = v && !es && !ef;
            if (rst) begin
                pipe = {bub, bub};
                mode = 0;
                ea = 0;
                eb = 0;
                ebub = 1;
            end else begin
                if (!adm) begin
                    ea = 0;
                    eb = 0;
                end else begin
                    if (apc) ea = 3;
                    else if (u1 && rs1 != 0 && ex.v && ex.rw && ex.rd == rs1) ea = 1;
                    else if (u1 && rs1 != 0 && mem.v && mem.rw && mem.rd == rs1) ea = 2;
                    else ea = 0;
                    if (bimm) eb = 3;
                    else if (u2 && rs2 != 0 && ex.v && ex.rw && ex.rd == rs2) eb = 1;
                    else if (u2 && rs2 != 0 && mem.v && mem.rw && mem.rd == rs2) eb = 2;
                    else eb = 0;
                end
                ebub = !adm;
                if (adm) pipe.push_front('{v: 1, rd: rd, rw: rw, ld: ld});
                else     pipe.push_front(bub);
                void'(pipe.pop_back());
                mode = br ? 2 : (es ? 1 : 0);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        nop();
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_x0_imm();
        test_branch_collision();
        test_reset_in_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: clk (rising edge) and reset.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs1, id_rs2  in  5  decode source registers
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_a_pc  in  1  operand A is the PC
- id_b_imm  in  1  operand B is the immediate
- id_rd  in  5  decode destination register
- id_reg_write  in  1  decode writes rd
- id_is_load  in  1  decode is a load
- branch_taken  in  1  EX-stage branch/jump redirect
- fwd_a_sel  out  2  operand A 4:1 mux select for EX
- fwd_b_sel  out  2  operand B 4:1 mux select for EX
- stall  out  1  hold PC and IF/ID
- flush  out  1  kill IF/ID contents
- ex_bubble  out  1  EX stage holds an inserted bubble

Function
REQ-003 Select encoding SHALL be: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 PC (A) or immediate (B).
REQ-004 The block SHALL keep internal tracking for EX and MEM stages: {valid, rd, reg_write, is_load}. These entries advance each cycle; the ID→EX entry loads only when the ID instruction is admitted.
REQ-005 Admission: the ID instruction is admitted when id_valid=1, stall=0, and flush=0. Otherwise the EX entry loads a bubble: valid=0 and ex_bubble=1 in the next cycle.
REQ-006 Selects SHALL be registered. They are computed in ID and become visible in the cycle the instruction occupies EX. Latency is 1 clock.
REQ-007 Operand A select, in priority order:
- 11 if id_a_pc=1
- 01 if id_use_rs1=1, rs1≠0, and the current EX entry is valid with reg_write and rd==rs1
- 10 if the same match is against the current MEM entry
- 00 otherwise
REQ-008 Operand B SHALL use the same priority as REQ-007, with id_b_imm in place of id_a_pc and rs2 in place of rs1.
REQ-009 Register x0 SHALL never be forwarded.
REQ-010 When both the EX and MEM entries match, EX SHALL win.
REQ-011 Load-use: in state RUN, stall SHALL be 1 combinationally when id_valid=1 and the EX entry is a valid load whose rd (≠0) matches a used rs1 or rs2. The FSM then goes to STALL.
REQ-012 FSM states SHALL be RUN, STALL, and FLUSH.
- RUN→STALL on a load-use hazard.
- STALL→RUN after exactly 1 cycle. stall=0 in STALL. The load is now in MEM, so the instruction is admitted with select 10.
- Any state→FLUSH on branch_taken.
- FLUSH→RUN after 1 cycle, unless branch_taken is asserted again.
REQ-013 flush SHALL be 1 in the cycle branch_taken=1 and throughout state FLUSH. No instruction is admitted in either cycle.
REQ-014 When branch_taken and a load-use hazard occur in the same cycle, branch_taken SHALL win: flush=1, stall=0, next state FLUSH.
REQ-015 When id_valid=0, the block SHALL not stall and SHALL admit no instruction.
REQ-016 Selects for a bubble SHALL be 00.

Reset
REQ-017 When reset=1 at a clock edge, the block SHALL enter RUN and clear all tracking entries to invalid.
REQ-018 Output reset values: fwd_a_sel=00, fwd_b_sel=00, ex_bubble=1, stall=0, flush=0.
REQ-019 Reset SHALL take priority over every other input, including during STALL or FLUSH.

Structure
REQ-020 The select codes (SEL_RF, SEL_EXMEM, SEL_MEMWB, SEL_ALT) and the FSM state encodings SHALL live in a shared package, also used by the datapath mux instantiation.
REQ-021 The block SHALL contain one sub-module, fwd_pick, instantiated twice (operands A and B). fwd_pick is a combinational priority compare of one source register against the EX and MEM entries.

Verification
REQ-022 Back-to-back dependency: add x5 then add x6,x5,x1. The second instruction SHALL get fwd_a_sel=01 in EX, with no stall.
REQ-023 Distance-2 dependency: writer of x7, one independent instruction, then a reader of x7 on rs2. The reader SHALL get fwd_b_sel=10.
REQ-024 Load-use: lw x8 then add x9,x8,x8.
- stall=1 for exactly one cycle.
- ex_bubble=1 for that cycle.
- The add then shows fwd_a_sel=fwd_b_sel=10.
REQ-025 x0 and immediate: a writer of x0 followed by a reader of x0 SHALL give sel 00. A reader with id_b_imm=1 SHALL give fwd_b_sel=11 regardless of any rs2 match.
REQ-026 Branch collisions:
- branch_taken coinciding with a load-use hazard SHALL give flush=1 for 2 cycles and stall=0.
- A reset asserted during FLUSH SHALL return all outputs to their reset values on the next edge.
